// File: rtl/lsu_sb_arbiter.sv
// Store-buffer request arbiter: shares the buffer port between loads and committed
// stores, tracks the single outstanding load and keeps issue/stall counters.
module lsu_sb_arbiter #(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [3:0]       ld_mask,
    input  logic [TAG_W-1:0] ld_tag,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [3:0]       st_mask,
    output logic             ld_resp_valid,
    output logic [31:0]      ld_resp_data,
    output logic [TAG_W-1:0] ld_resp_tag,
    output logic             st_ack,
    output logic [31:0]      sb_load_addr,
    output logic [3:0]       sb_load_mask,
    output logic [31:0]      sb_store_addr,
    output logic [31:0]      sb_store_data,
    output logic [3:0]       sb_store_mask,
    input  logic             sb_full,
    input  logic             sb_load_resp,
    input  logic [31:0]      sb_load_data,
    input  logic             sb_store_resp,
    output logic             ld_timeout,
    output logic [31:0]      perf_loads,
    output logic [31:0]      perf_stores,
    output logic [31:0]      perf_full_stall
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, LD_ISSUE, LD_WAIT} state_t;

    state_t           state;
    logic             rr;
    logic             st_issue_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic [29:0]      pend_word;
    logic [TAG_W-1:0] pend_tag;
    logic             ld_elig;
    logic             st_elig;
    logic             contest;
    logic             tmo_hit;

    // sb_full lags one cycle, so a store is never granted right behind another.
    always_comb begin
        ld_elig  = !rst && ld_valid && (state == IDLE);
        st_elig  = !rst && st_valid && !sb_full && !st_issue_q &&
                   ((state == IDLE) || (st_addr[31:2] != pend_word));
        contest  = ld_elig && st_elig;
        ld_ready = ld_elig && !(contest && rr);
        st_ready = st_elig && !(contest && !rr);
    end

    assign tmo_hit       = (state == LD_WAIT) && !sb_load_resp &&
                           (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign ld_resp_valid = sb_load_resp && (state == LD_WAIT);
    assign ld_resp_data  = sb_load_data;
    assign ld_resp_tag   = pend_tag;
    assign st_ack        = sb_store_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            ld_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_ready) state <= LD_ISSUE;
                end
                LD_ISSUE: begin
                    state   <= LD_WAIT;
                    tmo_cnt <= '0;
                end
                LD_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (sb_load_resp || tmo_hit) state <= IDLE;
                    if (tmo_hit) ld_timeout <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr         <= 1'b0;
            st_issue_q <= 1'b0;
            pend_word  <= '0;
            pend_tag   <= '0;
        end else begin
            st_issue_q <= st_ready;
            if (contest) rr <= ~rr;
            if (ld_ready) begin
                pend_word <= ld_addr[31:2];
                pend_tag  <= ld_tag;
            end
        end
    end

    // Issue registers hold a payload for exactly the cycle after its grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_load_addr  <= '0;
            sb_load_mask  <= '0;
            sb_store_addr <= '0;
            sb_store_data <= '0;
            sb_store_mask <= '0;
        end else begin
            sb_load_addr  <= ld_ready ? ld_addr : 32'd0;
            sb_load_mask  <= ld_ready ? ld_mask : 4'd0;
            sb_store_addr <= st_ready ? st_addr : 32'd0;
            sb_store_data <= st_ready ? st_data : 32'd0;
            sb_store_mask <= st_ready ? st_mask : 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loads      <= '0;
            perf_stores     <= '0;
            perf_full_stall <= '0;
        end else begin
            if (ld_ready) perf_loads <= perf_loads + 32'd1;
            if (st_ready) perf_stores <= perf_stores + 32'd1;
            if (st_valid && sb_full) perf_full_stall <= perf_full_stall + 32'd1;
        end
    end

endmodule

// File: tb/tb_lsu_sb_arbiter.sv
// Bench for lsu_sb_arbiter: directed scenarios plus random traffic, every cycle
// checked against a cycle-count based reference model.
module tb_lsu_sb_arbiter;
    localparam int TAG_W = 5;
    localparam int TMO   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ld_valid, st_valid, sb_full, sb_load_resp, sb_store_resp;
    logic [31:0] ld_addr, st_addr, st_data, sb_load_data;
    logic [3:0] ld_mask, st_mask;
    logic [TAG_W-1:0] ld_tag;
    logic ld_ready, st_ready, ld_resp_valid, st_ack, ld_timeout;
    logic [31:0] ld_resp_data, sb_load_addr, sb_store_addr, sb_store_data;
    logic [3:0] sb_load_mask, sb_store_mask;
    logic [TAG_W-1:0] ld_resp_tag;
    logic [31:0] perf_loads, perf_stores, perf_full_stall;

    lsu_sb_arbiter #(.TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_mask(ld_mask), .ld_tag(ld_tag),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_mask(st_mask),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .ld_resp_tag(ld_resp_tag), .st_ack(st_ack),
        .sb_load_addr(sb_load_addr), .sb_load_mask(sb_load_mask),
        .sb_store_addr(sb_store_addr), .sb_store_data(sb_store_data),
        .sb_store_mask(sb_store_mask),
        .sb_full(sb_full), .sb_load_resp(sb_load_resp),
        .sb_load_data(sb_load_data), .sb_store_resp(sb_store_resp),
        .ld_timeout(ld_timeout), .perf_loads(perf_loads),
        .perf_stores(perf_stores), .perf_full_stall(perf_full_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: load progress is tracked by the grant cycle number
    int cyc = 0;
    int m_gcyc, m_last_st;
    bit m_pend, m_rr, m_tmo;
    logic [31:0] m_paddr;
    logic [TAG_W-1:0] m_ptag;
    logic [31:0] e_la, e_sa, e_sd, m_nl, m_ns, m_nf;
    logic [3:0] e_lm, e_sm;
    bit r_ld_rdy, r_st_rdy, r_contest, r_resp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic mdl_rst();
        m_pend = 0; m_rr = 0; m_tmo = 0; m_last_st = -100; m_gcyc = 0;
        m_paddr = '0; m_ptag = '0;
        e_la = '0; e_lm = '0; e_sa = '0; e_sd = '0; e_sm = '0;
        m_nl = '0; m_ns = '0; m_nf = '0;
    endtask

    task automatic zero_in();
        ld_valid = 0; ld_addr = '0; ld_mask = '0; ld_tag = '0;
        st_valid = 0; st_addr = '0; st_data = '0; st_mask = '0;
        sb_full = 0; sb_load_resp = 0; sb_load_data = '0; sb_store_resp = 0;
    endtask

    // Called just after a negedge with inputs set; checks, advances model, returns at next negedge.
    task automatic tick();
        bit idle, in_wait, resp_v, tmo_now, lel, sel, lg, sg;
        int wc;
        #1;
        idle    = !m_pend;
        in_wait = m_pend && (cyc >= m_gcyc + 2);
        wc      = cyc - m_gcyc - 2;
        resp_v  = in_wait && sb_load_resp;
        tmo_now = in_wait && !sb_load_resp && (wc == TMO - 1);
        lel     = ld_valid && idle;
        sel     = st_valid && !sb_full && (cyc != m_last_st + 1) &&
                  (idle || (st_addr[31:2] != m_paddr[31:2]));
        if (lel && sel) begin lg = !m_rr; sg = m_rr; end
        else begin lg = lel; sg = sel; end

        chk("ld_ready", 32'(ld_ready), 32'(lg));
        chk("st_ready", 32'(st_ready), 32'(sg));
        chk("ld_resp_valid", 32'(ld_resp_valid), 32'(resp_v));
        if (resp_v) begin
            chk("ld_resp_data", ld_resp_data, sb_load_data);
            chk("ld_resp_tag", 32'(ld_resp_tag), 32'(m_ptag));
        end
        chk("st_ack", 32'(st_ack), 32'(sb_store_resp));
        chk("sb_load_addr", sb_load_addr, e_la);
        chk("sb_load_mask", 32'(sb_load_mask), 32'(e_lm));
        chk("sb_store_addr", sb_store_addr, e_sa);
        chk("sb_store_data", sb_store_data, e_sd);
        chk("sb_store_mask", 32'(sb_store_mask), 32'(e_sm));
        chk("ld_timeout", 32'(ld_timeout), 32'(m_tmo));
        chk("perf_loads", perf_loads, m_nl);
        chk("perf_stores", perf_stores, m_ns);
        chk("perf_full_stall", perf_full_stall, m_nf);

        r_ld_rdy = ld_ready; r_st_rdy = st_ready; r_contest = lel && sel; r_resp = resp_v;

        e_la = lg ? ld_addr : '0;  e_lm = lg ? ld_mask : '0;
        e_sa = sg ? st_addr : '0;  e_sd = sg ? st_data : '0;  e_sm = sg ? st_mask : '0;
        if (lel && sel) m_rr = !m_rr;
        if (lg) begin
            m_pend = 1; m_gcyc = cyc; m_paddr = ld_addr; m_ptag = ld_tag; m_nl++;
        end
        if (resp_v || tmo_now) m_pend = 0;
        if (tmo_now) m_tmo = 1;
        if (sg) begin m_last_st = cyc; m_ns++; end
        if (st_valid && sb_full) m_nf++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; zero_in(); mdl_rst();
        tick(); tick();
        rst = 0;
    endtask

    task automatic issue_load(input logic [31:0] a, input logic [TAG_W-1:0] t);
        ld_valid = 1; ld_addr = a; ld_mask = 4'hF; ld_tag = t;
        tick();
        ld_valid = 0;
    endtask

    logic [31:0] addrs [4];
    logic [31:0] base;
    logic [3:0] pat;
    bit seen, done;

    initial begin
        addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h106; addrs[3] = 32'h200;
        zero_in(); mdl_rst();
        do_reset();

        // single load with data return
        issue_load(32'h100, 5'd3);
        #1 chk("t1_issue_mask", 32'(sb_load_mask), 32'hF);
        tick(); tick();
        sb_load_resp = 1; sb_load_data = 32'hDEADBEEF;
        #1 chk("t1_resp_valid", 32'(ld_resp_valid), 32'd1);
        chk("t1_resp_data", ld_resp_data, 32'hDEADBEEF);
        chk("t1_resp_tag", 32'(ld_resp_tag), 32'd3);
        tick();
        sb_load_resp = 0;
        #1 chk("t1_perf_loads", perf_loads, 32'd1);
        tick();

        // back-to-back stores: one every other cycle
        base = perf_stores;
        st_valid = 1; st_addr = 32'h300; st_mask = 4'h3;
        for (int i = 0; i < 4; i++) begin
            st_data = 32'h1000 + 32'(i);
            #1 pat[i] = st_ready;
            tick();
        end
        st_valid = 0;
        chk("t2_grant_pattern", 32'(pat), 32'h5);
        chk("t2_perf_stores", perf_stores - base, 32'd2);
        tick();

        // contested requests: load first, then store after the load completes
        do_reset();
        ld_valid = 1; ld_addr = 32'h300; ld_mask = 4'h1; ld_tag = 5'd9;
        st_valid = 1; st_addr = 32'h400; st_data = 32'h55; st_mask = 4'hF;
        sb_load_resp = 1; sb_load_data = 32'h77;
        #1 chk("t3_first_ld", 32'(ld_ready), 32'd1);
        chk("t3_first_st", 32'(st_ready), 32'd0);
        tick();
        seen = 0; done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            if (seen && r_contest) begin
                chk("t3_store_wins", 32'(r_st_rdy), 32'd1);
                chk("t3_load_loses", 32'(r_ld_rdy), 32'd0);
                done = 1;
            end
            if (r_resp) seen = 1;
        end
        chk("t3_contest_seen", 32'(done), 32'd1);
        zero_in(); tick(); tick(); tick();

        // store to the pending load's word is held off until the response
        do_reset();
        issue_load(32'h104, 5'd7);
        st_valid = 1; st_addr = 32'h104; st_data = 32'hABCD; st_mask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_same_blocked", 32'(st_ready), 32'd0);
            tick();
        end
        sb_load_resp = 1; sb_load_data = 32'h1234;
        #1 chk("t4_blocked_at_resp", 32'(st_ready), 32'd0);
        tick();
        sb_load_resp = 0;
        #1 chk("t4_after_resp", 32'(st_ready), 32'd1);
        tick();
        st_valid = 0; tick();
        issue_load(32'h104, 5'd8);
        st_valid = 1; st_addr = 32'h200;
        #1 chk("t4_other_granted", 32'(st_ready), 32'd1);
        tick();
        st_valid = 0; sb_load_resp = 1;
        tick(); tick();
        sb_load_resp = 0; tick();

        // full back-pressure
        base = perf_full_stall;
        st_valid = 1; st_addr = 32'h500; sb_full = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t5_full_stall", 32'(st_ready), 32'd0);
            tick();
        end
        sb_full = 0;
        #1 chk("t5_grant_after_full", 32'(st_ready), 32'd1);
        chk("t5_perf_full", perf_full_stall - base, 32'd5);
        tick();
        st_valid = 0; tick();

        // response exactly at the timeout boundary counts as a response
        do_reset();
        issue_load(32'h600, 5'd2);
        for (int i = 1; i <= 9; i++) begin
            sb_load_resp = (i == 9); sb_load_data = 32'hC0FFEE00;
            #1 chk("t6_boundary_resp", 32'(ld_resp_valid), 32'(i == 9));
            tick();
        end
        sb_load_resp = 0;
        #1 chk("t6_no_timeout", 32'(ld_timeout), 32'd0);
        tick();

        // genuine timeout, then a spurious response in IDLE
        issue_load(32'h600, 5'd4);
        for (int i = 1; i <= 9; i++) begin
            ld_valid = (i == 9);
            #1 chk("t6_no_resp", 32'(ld_resp_valid), 32'd0);
            if (i == 9) chk("t6_still_waiting", 32'(ld_ready), 32'd0);
            tick();
        end
        #1 chk("t6_idle_again", 32'(ld_ready), 32'd1);
        chk("t6_timeout_flag", 32'(ld_timeout), 32'd1);
        ld_valid = 0;
        tick();
        sb_load_resp = 1; sb_load_data = 32'h99;
        #1 chk("t6_spurious", 32'(ld_resp_valid), 32'd0);
        tick();
        sb_load_resp = 0; tick();

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ld_valid      = 1'($urandom_range(0, 1));
            ld_addr       = addrs[$urandom_range(0, 3)];
            ld_mask       = 4'($urandom_range(1, 15));
            ld_tag        = TAG_W'($urandom);
            st_valid      = 1'($urandom_range(0, 1));
            st_addr       = addrs[$urandom_range(0, 3)];
            st_data       = $urandom;
            st_mask       = 4'($urandom_range(1, 15));
            sb_full       = ($urandom_range(0, 3) == 0);
            sb_load_resp  = ($urandom_range(0, 9) < 2);
            sb_load_data  = $urandom;
            sb_store_resp = 1'($urandom_range(0, 1));
            tick();
        end

        // reset while a load is pending drops it
        zero_in(); tick();
        issue_load(32'h104, 5'd5);
        tick();
        do_reset();
        sb_load_resp = 1; sb_load_data = 32'h42;
        #1 chk("t7_dropped_load", 32'(ld_resp_valid), 32'd0);
        tick();
        zero_in(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_sb_arbiter.md
# lsu_sb_arbiter

Arbiter and sequencer in front of the data-side store buffer. It shares the buffer's single request port between the load unit and the store-commit path. It enforces the buffer's one-outstanding-load limit and its full back-pressure, hides the buffer's one-cycle-stale `full`, and filters spurious load responses. It also returns tagged load data to the load unit and keeps issue and stall performance counters.

## Interface
- `TAG_W`, 5: width of the load tag (ROB index) carried with each load.
- `TIMEOUT`, 1024: cycles in LD_WAIT before a load is abandoned.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `ld_valid` in 1: load request valid.
- `ld_ready` out 1: load request accepted this cycle.
- `ld_addr` in 32: load address.
- `ld_mask` in 4: load byte mask; nonzero whenever `ld_valid` is high.
- `ld_tag` in TAG_W: load tag.
- `st_valid` in 1: committed store valid.
- `st_ready` out 1: store accepted this cycle.
- `st_addr` in 32, `st_data` in 32, `st_mask` in 4: store payload; `st_mask` is nonzero.
- `ld_resp_valid` out 1: load data valid.
- `ld_resp_data` out 32: load data.
- `ld_resp_tag` out TAG_W: tag of the returning load.
- `st_ack` out 1: store accepted by the buffer.
- `sb_load_addr` out 32, `sb_load_mask` out 4: load issue to the buffer.
- `sb_store_addr` out 32, `sb_store_data` out 32, `sb_store_mask` out 4: store issue to the buffer.
- `sb_full` in 1, `sb_load_resp` in 1, `sb_load_data` in 32, `sb_store_resp` in 1: buffer status and responses.
- `ld_timeout` out 1: sticky flag, set when a load times out.
- `perf_loads` out 32, `perf_stores` out 32, `perf_full_stall` out 32: performance counters.

## Operation
- FSM states:
  - IDLE to LD_ISSUE on load grant.
  - LD_ISSUE to LD_WAIT unconditionally.
  - LD_WAIT to IDLE on `sb_load_resp`, or on timeout.
- Load eligibility: `ld_valid` and state IDLE. Only one load is outstanding at any time.
- Store eligibility, all of the following:
  - `st_valid`.
  - `!sb_full`.
  - `st_issue_q == 0`, i.e. no store was issued in the previous cycle.
  - When the state is not IDLE: `st_addr[31:2] != pend_addr[31:2]`. This blocks stale forwarding into a pending load.
- Upstream guarantees ordering: stores are committed, and loads are sent only when no older store is uncommitted.
- Grant in IDLE:
  - At most one grant per cycle.
  - When both requests are eligible, round-robin bit `rr`: 0 grants the load, 1 grants the store.
  - `rr` toggles only after a contested grant.
- Grant outside IDLE: only stores can be granted.
- `ld_ready` and `st_ready` are the combinational grants.
- Accepted load: latch `pend_addr`, `pend_mask` and `pend_tag`.
- Issue registers:
  - The accepted payload is driven on `sb_*` in the next cycle for exactly one cycle.
  - All `sb_*` fields are 0 in every other cycle.
- Load response:
  - `ld_resp_valid = sb_load_resp && state==LD_WAIT`.
  - `ld_resp_data = sb_load_data`, `ld_resp_tag = pend_tag`. Both are combinational.
  - `sb_load_resp` in IDLE or LD_ISSUE is ignored. This covers the buffer's spurious response, produced when its cache responds while the buffer is empty.
- `st_ack = sb_store_resp` (pass-through).
- Timeout:
  - Counter is cleared on entry to LD_WAIT and increments each LD_WAIT cycle.
  - At `TIMEOUT-1` with no response: go to IDLE with no response and set `ld_timeout`. Only reset clears `ld_timeout`.
- Counters wrap at 2^32:
  - `perf_loads` +1 per load grant.
  - `perf_stores` +1 per store grant.
  - `perf_full_stall` +1 for each cycle with `st_valid && sb_full`.

## Timing
- Reset values: state IDLE, `rr=0`, `st_issue_q=0`, timeout counter 0. All outputs are 0, including `ld_timeout` and all counters.
- Reset mid-operation drops the pending load. No response for it is ever produced.
- Load grant in cycle N:
  - `sb_load_*` valid in N+1 (LD_ISSUE).
  - LD_WAIT from N+2. The earliest response is in N+2 (buffer forwarding hit).
  - Next `ld_ready` no earlier than the cycle after the response.
- Store grant in cycle N: `sb_store_*` in N+1, `st_ready` forced low in N+1, and `sb_full` is fresh in N+2. Peak rate is one store per 2 cycles.
- A store grant is allowed during LD_ISSUE or LD_WAIT. It issues concurrently with the load on the separate store fields.
- A response arriving in the same cycle as the timeout boundary counts as a response: `ld_resp_valid=1` and `ld_timeout` stays 0.

## Test plan
- Single load, address 0x100, mask 0xF, tag 3, with a response two cycles after issue carrying data 0xDEADBEEF:
  - `sb_load_mask=F` for one cycle.
  - `ld_resp_valid=1`, data 0xDEADBEEF, tag 3.
  - `perf_loads=1`.
- Back-to-back stores with `st_valid` held high for 4 cycles and `sb_full=0`:
  - Grants on cycles 0 and 2 only.
  - `perf_stores=2`.
- Both requests valid continuously from reset:
  - First grant goes to the load (`rr=0`).
  - After the load completes, the next contested grant goes to the store.
- Store to 0x104 while a load to 0x104 is pending: `st_ready=0` until the response. A store to 0x200 under the same condition is granted immediately.
- `sb_full=1` for 5 cycles with `st_valid` high:
  - No grant during those cycles.
  - `perf_full_stall=5`.
  - A grant follows the first cycle with `sb_full=0`.
- Timeout and spurious-response filtering:
  - `TIMEOUT=8` with no response: return to IDLE after 8 LD_WAIT cycles, `ld_timeout=1`, no `ld_resp_valid`.
  - `sb_load_resp` pulsed in IDLE: `ld_resp_valid` stays 0.
